pixel_stream_framer: RTL and testbench

//  Downstream of the pixel source stage. Consumes its 64-bit two-pixel words
//  ({8'h0,R,G,B} x2) over a valid/ready handshake and re-emits them as a

---
 rtl/pixel_stream_framer.sv | 183 ++++++++++++++++++
 tb/tb_pixel_stream_framer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_framer.sv
// Frames a two-pixel word stream into lines/frames (tuser = SOF, tlast = EOL)
// behind a registered output stage plus one skid entry.
module pixel_stream_framer #(
  parameter int DATA_W  = 64,
  parameter int H_WORDS = 960,
  parameter int V_LINES = 1080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int CW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_LINES - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic              state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_user_q, out_user_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic              skid_user_q, skid_user_d;

  logic push_s, pop_s, in_user_s, in_last_s, eof_s;

  // Framing FSM, position counters and the two-entry buffer next-state logic.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    frame_count_d = frame_count_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_user_d    = out_user_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_last_d   = skid_last_q;
    skid_user_d   = skid_user_q;

    push_s    = s_valid && s_ready_q && (state_q == ST_RUN);
    pop_s     = out_valid_q && m_tready;
    in_user_s = (col_q == '0) && (row_q == '0);
    in_last_s = (col_q == COL_LAST);
    eof_s     = in_last_s && (row_q == ROW_LAST);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (push_s) begin
          if (in_last_s) begin
            col_d = '0;
            if (eof_s) begin
              row_d         = '0;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = enable ? ST_RUN : ST_IDLE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase

    // The output register refills from the skid entry first to keep order.
    if (!out_valid_q || pop_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        skid_valid_d = push_s;
        if (push_s) begin
          skid_data_d = s_data;
          skid_last_d = in_last_s;
          skid_user_d = in_user_s;
        end else begin
          skid_data_d = skid_data_q;
        end
      end else if (push_s) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data;
        out_last_d  = in_last_s;
        out_user_d  = in_user_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push_s) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
      skid_last_d  = in_last_s;
      skid_user_d  = in_user_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end

    s_ready_d = (state_d == ST_IDLE) ? 1'b1 : !skid_valid_d;
    busy_d    = (state_d == ST_RUN) || out_valid_d;
  end

  // State, counters and buffer registers; async reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= 16'd0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_user_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
      skid_user_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_user_q    <= out_user_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_last_q   <= skid_last_d;
      skid_user_q   <= skid_user_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_tdata     = out_data_q;
  assign m_tvalid    = out_valid_q;
  assign m_tlast     = out_last_q;
  assign m_tuser     = out_user_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Directed bench: a 4x2 framer for handshake/framing/reset cases and a
// 1x1 framer for the frame counter wrap.
module tb_pixel_stream_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, s_valid, m_tready;
  logic [63:0] s_data;
  logic        s_ready, m_tvalid, m_tlast, m_tuser, busy;
  logic [63:0] m_tdata;
  logic [15:0] frame_count;

  logic        enable1, s_valid1, m_tready1;
  logic [63:0] s_data1;
  logic        s_ready1, m_tvalid1, m_tlast1, m_tuser1, busy1;
  logic [63:0] m_tdata1;
  logic [15:0] frame_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_stream_framer #(.DATA_W(64), .H_WORDS(4), .V_LINES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .frame_count(frame_count), .busy(busy)
  );

  pixel_stream_framer #(.DATA_W(64), .H_WORDS(1), .V_LINES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable1), .s_data(s_data1),
    .s_valid(s_valid1), .s_ready(s_ready1), .m_tdata(m_tdata1),
    .m_tvalid(m_tvalid1), .m_tready(m_tready1), .m_tlast(m_tlast1),
    .m_tuser(m_tuser1), .frame_count(frame_count1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int k);
    return {32'hA5A5_0000, 32'(k)};
  endfunction

  // Send word k of a 4x2 frame and check it on the output the next cycle.
  task automatic send(input int k);
    s_data  = wd(k);
    s_valid = 1'b1;
    step();
    chk($sformatf("word%0d", k), 80'({m_tvalid, m_tuser, m_tlast, m_tdata}),
        80'({1'b1, (k == 1), (k % 4 == 0), wd(k)}));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b1; m_tready = 1'b1; s_data = 64'd0;
    enable1 = 1'b0; s_valid1 = 1'b0; m_tready1 = 1'b1; s_data1 = 64'd0;

    // 1: reset state, then IDLE discards words
    step(); step();
    chk("rst_s_ready", 80'(s_ready), 80'd0);
    chk("rst_m_tvalid", 80'(m_tvalid), 80'd0);
    chk("rst_frame_count", 80'(frame_count), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    rst_n = 1'b1;
    step();
    chk("s_ready_after_rst", 80'(s_ready), 80'd1);
    for (int i = 0; i < 10; i++) begin
      s_data = 64'(i + 100);
      step();
      chk("idle_discard", 80'({m_tvalid, s_ready, busy}), 80'(3'b010));
    end

    // 2: enable, full-rate frame of 8 words
    s_valid = 1'b0; enable = 1'b1;
    step();
    chk("busy_run", 80'(busy), 80'd1);
    for (int k = 1; k <= 8; k++) send(k);
    chk("fc_frame1", 80'(frame_count), 80'd1);
    s_valid = 1'b0;
    step();
    chk("drain1", 80'(m_tvalid), 80'd0);

    // 3: backpressure after word 2
    send(1);
    send(2);
    m_tready = 1'b0;
    s_data = wd(3);
    step();
    chk("stall_s_ready", 80'(s_ready), 80'd0);
    chk("stall_hold_a", 80'({m_tvalid, m_tuser, m_tlast, m_tdata}), 80'({3'b100, wd(2)}));
    s_data = wd(4);
    step();
    chk("stall_hold_b", 80'({s_ready, m_tvalid, m_tdata}), 80'({2'b01, wd(2)}));
    step();
    chk("stall_hold_c", 80'({s_ready, m_tvalid, m_tdata}), 80'({2'b01, wd(2)}));
    m_tready = 1'b1;
    step();
    chk("unstall_w3", 80'({s_ready, m_tvalid, m_tuser, m_tlast, m_tdata}), 80'({4'b1100, wd(3)}));
    for (int k = 4; k <= 8; k++) send(k);
    chk("fc_frame2", 80'(frame_count), 80'd2);
    s_valid = 1'b0;
    step();
    chk("drain2", 80'(m_tvalid), 80'd0);

    // 4: enable dropped mid-frame
    for (int k = 1; k <= 3; k++) send(k);
    enable = 1'b0;
    for (int k = 4; k <= 8; k++) send(k);
    chk("fc_frame3", 80'(frame_count), 80'd3);
    chk("busy_draining", 80'(busy), 80'd1);
    s_valid = 1'b0;
    step();
    chk("idle_busy", 80'({busy, m_tvalid}), 80'd0);
    for (int i = 0; i < 5; i++) begin
      s_data = 64'(i + 200);
      s_valid = 1'b1;
      step();
      chk("idle_discard2", 80'({m_tvalid, s_ready, frame_count}), 80'({2'b01, 16'd3}));
    end

    // 5: reset mid-frame, then a fresh frame
    s_valid = 1'b0; enable = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) send(k);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 80'({m_tvalid, s_ready, busy, frame_count}), 80'd0);
    s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rerun_ready", 80'({s_ready, busy, m_tvalid}), 80'(3'b110));
    for (int k = 1; k <= 8; k++) send(k);
    chk("fc_restart", 80'(frame_count), 80'd1);
    s_valid = 1'b0;

    // 6: 1x1 frames, counter wrap
    enable1 = 1'b1;
    step(); step();
    s_valid1 = 1'b1;
    for (int i = 1; i <= 65536; i++) begin
      s_data1 = 64'(i);
      step();
      chk("w1x1", 80'({m_tvalid1, m_tuser1, m_tlast1, m_tdata1}), 80'({3'b111, 64'(i)}));
      if (i == 1) chk("fc1x1_first", 80'(frame_count1), 80'd1);
      if (i == 65535) chk("fc1x1_max", 80'(frame_count1), 80'(16'hFFFF));
    end
    chk("fc1x1_wrap", 80'(frame_count1), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
